// File: rtl/id_stage_param_if.sv
// Bus between IF/ID, the ID stage, ID/EX and the MEM/WB write-back port.
// The master side drives the IF/ID word, write-back and flush; the slave side is the ID stage.
interface id_stage_param_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    // if_id_valid qualifies if_id_instr/if_id_npc. stall is the back-pressure:
    // while stall=1 the producer must hold PC and IF/ID, and the word is
    // consumed at the first rising edge where stall=0 (or it is flushed).
    logic              if_id_valid;
    logic [31:0]       if_id_instr;
    logic [DATA_W-1:0] if_id_npc;
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_writereg;
    logic [DATA_W-1:0] wb_writedata;
    logic              ex_flush;
    logic              stall;
    logic              id_ex_valid;
    logic [8:0]        id_ex_ctrl;
    logic [DATA_W-1:0] id_ex_npc;
    logic [DATA_W-1:0] id_ex_rdata1;
    logic [DATA_W-1:0] id_ex_rdata2;
    logic [DATA_W-1:0] id_ex_imm;
    logic [REG_AW-1:0] id_ex_rs;
    logic [REG_AW-1:0] id_ex_rt;
    logic [REG_AW-1:0] id_ex_rd;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output if_id_valid, if_id_instr, if_id_npc,
        output wb_regwrite, wb_writereg, wb_writedata, ex_flush,
        input  stall, id_ex_valid, id_ex_ctrl, id_ex_npc, id_ex_rdata1,
        input  id_ex_rdata2, id_ex_imm, id_ex_rs, id_ex_rt, id_ex_rd, stall_count
    );

    modport slave (
        input  if_id_valid, if_id_instr, if_id_npc,
        input  wb_regwrite, wb_writereg, wb_writedata, ex_flush,
        output stall, id_ex_valid, id_ex_ctrl, id_ex_npc, id_ex_rdata1,
        output id_ex_rdata2, id_ex_imm, id_ex_rs, id_ex_rt, id_ex_rd, stall_count
    );
endinterface

// File: rtl/id_stage_param.sv
// MIPS decode stage with register file, load-use stall, branch flush and ID/EX latch.
// Optional macro ID_WB_BYPASS_EN: write-back data is forwarded to same-cycle register reads.
module id_stage_param #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic             clk,
    input logic             reset,
    id_stage_param_if.slave bus
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam int         MEMREAD_BIT = 3;

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [8:0]        dec_ctrl;
    logic              uses_rt;
    logic [DATA_W-1:0] rdata1, rdata2, imm;
    logic              stall_w;

    logic [DATA_W-1:0] regs [NREG];

    logic              q_valid;
    logic [8:0]        q_ctrl;
    logic [DATA_W-1:0] q_npc, q_rdata1, q_rdata2, q_imm;
    logic [REG_AW-1:0] q_rs, q_rt, q_rd;
    logic [CNT_W-1:0]  q_count;

    assign opcode = bus.if_id_instr[31:26];
    assign rs     = bus.if_id_instr[21 +: REG_AW];
    assign rt     = bus.if_id_instr[16 +: REG_AW];
    assign rd     = bus.if_id_instr[11 +: REG_AW];
    assign imm    = {{(DATA_W-16){bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};

    always_comb begin
        dec_ctrl = 9'b000000000;
        uses_rt  = 1'b0;
        case (opcode)
            OP_R:    begin dec_ctrl = 9'b110000010; uses_rt = 1'b1; end
            OP_LW:   dec_ctrl = 9'b000101011;
            OP_SW:   begin dec_ctrl = 9'b000100100; uses_rt = 1'b1; end
            OP_BEQ:  begin dec_ctrl = 9'b001010000; uses_rt = 1'b1; end
            OP_ADDI: dec_ctrl = 9'b000100010;
            default: dec_ctrl = 9'b000000000;
        endcase
    end

    // r0 is never written, but the explicit zero on read keeps it hardwired.
    always_comb begin
        rdata1 = (rs == '0) ? '0 : regs[rs];
        rdata2 = (rt == '0) ? '0 : regs[rt];
`ifdef ID_WB_BYPASS_EN
        if (bus.wb_regwrite && bus.wb_writereg != '0) begin
            if (bus.wb_writereg == rs) rdata1 = bus.wb_writedata;
            if (bus.wb_writereg == rt) rdata2 = bus.wb_writedata;
        end
`endif
    end

    // A load in ID/EX whose destination the instruction in ID consumes.
    assign stall_w = q_valid && q_ctrl[MEMREAD_BIT] && (q_rt != '0) && bus.if_id_valid &&
                     ((q_rt == rs) || ((q_rt == rt) && uses_rt));

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (bus.wb_regwrite && bus.wb_writereg != '0) begin
            regs[bus.wb_writereg] <= bus.wb_writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || bus.ex_flush || stall_w) begin
            q_valid  <= 1'b0;
            q_ctrl   <= '0;
            q_npc    <= '0;
            q_rdata1 <= '0;
            q_rdata2 <= '0;
            q_imm    <= '0;
            q_rs     <= '0;
            q_rt     <= '0;
            q_rd     <= '0;
        end else begin
            q_valid  <= bus.if_id_valid;
            q_ctrl   <= bus.if_id_valid ? dec_ctrl : 9'b000000000;
            q_npc    <= bus.if_id_npc;
            q_rdata1 <= rdata1;
            q_rdata2 <= rdata2;
            q_imm    <= imm;
            q_rs     <= rs;
            q_rt     <= rt;
            q_rd     <= rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_count <= '0;
        end else if (stall_w && !bus.ex_flush && q_count != '1) begin
            q_count <= q_count + 1'b1;
        end
    end

    assign bus.stall        = stall_w;
    assign bus.id_ex_valid  = q_valid;
    assign bus.id_ex_ctrl   = q_ctrl;
    assign bus.id_ex_npc    = q_npc;
    assign bus.id_ex_rdata1 = q_rdata1;
    assign bus.id_ex_rdata2 = q_rdata2;
    assign bus.id_ex_imm    = q_imm;
    assign bus.id_ex_rs     = q_rs;
    assign bus.id_ex_rt     = q_rt;
    assign bus.id_ex_rd     = q_rd;
    assign bus.stall_count  = q_count;
endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
Parametrised MIPS instruction-decode stage with an ID/EX pipeline register. It decodes the IF/ID instruction, reads a zero-hardwired register file, sign-extends the immediate and latches the result into ID/EX. Adds load-use hazard stalling, branch flush and a stall counter, none of which the fixed-width ID stage has. It sits between the IF/ID latch and the EX stage and receives the write-back port from MEM/WB.

Parameters:
DATA_W, 32, datapath and register width
NREG, 32, number of architectural registers (power of 2, ≤32)
REG_AW, 5, register index width (log2 NREG)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
if_id_valid  in  1  IF/ID holds a real instruction
if_id_instr  in  32  instruction word
if_id_npc  in  DATA_W  PC+4 from IF/ID
wb_regwrite  in  1  write-back enable
wb_writereg  in  REG_AW  write-back destination
wb_writedata  in  DATA_W  write-back data
ex_flush  in  1  branch taken (PCSrc); squash the instruction in ID
stall  out  1  combinational; hold PC and IF/ID this cycle
id_ex_valid  out  1  ID/EX holds a real instruction
id_ex_ctrl  out  9  {RegDst,ALUOp1,ALUOp0,ALUSrc,Branch,MemRead,MemWrite,RegWrite,MemtoReg}
id_ex_npc  out  DATA_W  latched NPC
id_ex_rdata1  out  DATA_W  rs read data
id_ex_rdata2  out  DATA_W  rt read data
id_ex_imm  out  DATA_W  sign-extended instr[15:0]
id_ex_rs, id_ex_rt, id_ex_rd  out  REG_AW each  instr[25:21], [20:16], [15:11] (low REG_AW bits)
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (reset==0 at posedge): every ID/EX output becomes 0, stall_count becomes 0, and all registers are cleared. stall is derived from the cleared state, so it is 0.
- Decode on opcode instr[31:26]:
  - 0x00 (R-type) -> 110000010
  - 0x23 (lw) -> 000101011
  - 0x2B (sw) -> 000100100
  - 0x04 (beq) -> 001010000
  - 0x08 (addi) -> 000100010
  - any other opcode -> 000000000
- Register file:
  - A write occurs at posedge when wb_regwrite=1 and wb_writereg≠0. Writes to r0 are ignored, and r0 always reads 0.
  - Reads are combinational on rs/rt.
- Sign extension: bit 15 of the instruction is replicated into bits DATA_W-1:16.
- Load-use hazard: stall=1 when all of the following hold:
  - id_ex_valid=1
  - id_ex_ctrl MemRead=1
  - id_ex_rt≠0
  - if_id_valid=1
  - id_ex_rt equals rs, or id_ex_rt equals rt and the opcode is R-type, sw or beq
- ID/EX update at each posedge (reset=1), in priority order:
  1. ex_flush=1 -> bubble (valid=0, ctrl=0; data fields don't-care but must be 0).
  2. stall=1 -> bubble.
  3. otherwise -> load decoded fields, with valid=if_id_valid and ctrl forced to 0 when if_id_valid=0.
- Latency: an instruction presented in cycle N appears on ID/EX after edge N+1. A stall adds exactly one bubble, because the stalling load has then moved out of ID/EX.
- stall_count: +1 on every posedge with stall=1 and ex_flush=0. It saturates at all-ones and does not wrap.
- ex_flush and stall together: flush wins, no count.
- Reset asserted mid-stall clears everything. The held instruction is re-decoded once the IF stage re-presents it.

Optional Feature:
Macro ID_WB_BYPASS_EN.
- Defined: a read whose index equals wb_writereg, while wb_regwrite=1 and the index is ≠0, returns wb_writedata in the same cycle (write-through). This removes the WB->ID hazard.
- Undefined: reads return the pre-write register contents, and the surrounding pipeline must guarantee a one-cycle separation.

Test Plan:
- Reset held 2 cycles with junk inputs -> all ID/EX outputs 0, stall=0, stall_count=0.
- Write r5=0x1234 via WB, then present add r3,r5,r0 (0x00A01820), npc=0x8 -> next edge: ctrl=110000010, rdata1=0x1234, rdata2=0, rd=3, npc=8.
- Present lw r2,-4(r1) (0x8C22FFFC) -> id_ex_imm=0xFFFFFFFC, ctrl=000101011. Then present add r4,r2,r2 -> stall=1 for one cycle, one bubble (valid=0), add enters the cycle after, stall_count=1.
- Present beq with ex_flush=1 and an active load-use stall in the same cycle -> bubble, stall_count unchanged.
- WB write to r0 with 0xFFFF -> a later read of r0 returns 0. Force 2^CNT_W+3 stalls (CNT_W=2 override) -> stall_count holds 3.
- Same-cycle WB write r7=0xAA and read of r7 -> rdata1=0xAA with ID_WB_BYPASS_EN defined, previous value without it.
